// File: rtl/hash_a_stream_buffer.sv
// First-word-fall-through buffer for matrix-A expander words: masks each 16-bit
// lane to LOG_Q bits on write and tags row ends / matrix completion on the pop side.
module hash_a_stream_buffer #(
  parameter int DEPTH         = 8,
  parameter int LOG_Q         = 15,
  parameter int WORDS_PER_ROW = 336,
  parameter int ROWS          = 1344
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [63:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [63:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [15:0]                row_idx,
  output logic                       matrix_done,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [15:0] LANE_MASK =
    (LOG_Q >= 16) ? 16'hFFFF : 16'((32'd1 << LOG_Q) - 32'd1);

  logic [63:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]    row_idx_q, row_idx_d;
  logic           matrix_done_q, matrix_done_d;
  logic           push, pop, last_pop, flush;

  function automatic logic [63:0] mask_word(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = w[16*i +: 16] & LANE_MASK;
    return r;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. in_ready and out_valid come only from registered occupancy, so neither
  // side's ready depends combinationally on the other side.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_last  = out_valid && (word_cnt_q == WCW'(WORDS_PER_ROW - 1));
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign row_idx     = row_idx_q;
  assign matrix_done = matrix_done_q;
  assign level       = count_q;

  assign flush    = !rst_n || clear;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign last_pop = pop && out_last;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    word_cnt_d    = word_cnt_q;
    row_idx_d     = row_idx_q;
    matrix_done_d = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop) word_cnt_d = last_pop ? '0 : word_cnt_q + WCW'(1);
    if (last_pop) begin
      if (row_idx_q == 16'(ROWS - 1)) begin
        row_idx_d     = '0;
        matrix_done_d = 1'b1;
      end else begin
        row_idx_d = row_idx_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      word_cnt_q    <= '0;
      row_idx_q     <= '0;
      matrix_done_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      word_cnt_q    <= word_cnt_d;
      row_idx_q     <= row_idx_d;
      matrix_done_q <= matrix_done_d;
    end
  end

  // Storage has no reset; a flush cycle never writes, so the offered word is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= mask_word(in_data);
  end

endmodule

// File: tb/tb_hash_a_stream_buffer.sv
// Bench for hash_a_stream_buffer: queue-based reference model checked every cycle,
// a masking vector table, and directed sequences for backpressure, row tags and flush.
module tb_hash_a_stream_buffer;
  localparam int DEPTH = 8;
  localparam int LOG_Q = 15;
  localparam int WPR   = 4;
  localparam int ROWS  = 3;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_last, matrix_done;
  logic [63:0] in_data, out_data;
  logic [15:0] row_idx;
  logic [3:0]  level;

  hash_a_stream_buffer #(.DEPTH(DEPTH), .LOG_Q(LOG_Q), .WORDS_PER_ROW(WPR), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .row_idx(row_idx), .matrix_done(matrix_done), .level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stored words, pops since the last flush, pending done pulse.
  logic [63:0] exp_q[$];
  int          m_pops = 0;
  bit          m_done = 1'b0;
  bit          model_on = 1'b0;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [63:0] ref_mask(input logic [63:0] w);
    logic [63:0] r;
    int v;
    for (int i = 0; i < 4; i++) begin
      v = int'(w[16*i +: 16]) % (1 << LOG_Q);
      r[16*i +: 16] = 16'(v);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_model();
    bit v;
    v = (exp_q.size() != 0);
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    chk("level", 64'(level), 64'(exp_q.size()));
    chk("out_data", out_data, v ? exp_q[0] : 64'd0);
    chk("out_last", 64'(out_last), 64'(v && (m_pops % WPR == WPR - 1)));
    chk("row_idx", 64'(row_idx), 64'((m_pops / WPR) % ROWS));
    chk("matrix_done", 64'(matrix_done), 64'(m_done));
  endtask

  task automatic model_edge();
    bit psh, pp;
    if (!rst_n || clear) begin
      exp_q.delete();
      m_pops = 0;
      m_done = 1'b0;
    end else begin
      psh = in_valid && (exp_q.size() < DEPTH);
      pp  = out_ready && (exp_q.size() != 0);
      m_done = pp && (m_pops % (WPR * ROWS) == WPR * ROWS - 1);
      if (pp) begin
        void'(exp_q.pop_front());
        m_pops++;
      end
      if (psh) exp_q.push_back(ref_mask(in_data));
    end
  endtask

  // One clock: compare current outputs, advance, let outputs settle.
  task automatic cyc();
    if (model_on) check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; in_data = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic push_words(input int n, input logic [63:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = base + 64'(i);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic mid_flush(input bit use_rst);
    do_clear();
    out_ready = 1'b0;
    push_words(4, 64'h1000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    out_ready = 1'b0;
    push_words(5, 64'h2000);
    chk("setup_level", 64'(level), 64'd5);
    chk("setup_row", 64'(row_idx), 64'd1);
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_CAFE_F00D;
    if (use_rst) rst_n = 1'b0; else clear = 1'b1;
    cyc();
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_row", 64'(row_idx), 64'd0);
    cyc();
    chk("flush_dropped", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int  pops_seen, md_cnt, md_cyc, pop12_cyc, lvl1_cnt;
    logic [15:0] last_mask;
    logic [63:0] pushed[10];

    vecs[0] = '{din: 64'hFFFF_8001_7FFF_0000, dout: 64'h7FFF_0001_7FFF_0000};
    vecs[1] = '{din: 64'h8000_8000_8000_8000, dout: 64'h0000_0000_0000_0000};
    vecs[2] = '{din: 64'h1234_ABCD_FFFF_7FFF, dout: 64'h1234_2BCD_7FFF_7FFF};
    vecs[3] = '{din: 64'hC001_4002_A5A5_5A5A, dout: 64'h4001_4002_25A5_5A5A};

    // Reset / idle
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    model_edge();
    #1;
    rst_n = 1'b1;
    model_on = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_out_data", out_data, 64'd0);

    // Latency and masking table, with stall hold
    foreach (vecs[k]) begin
      out_ready = 1'b0; in_valid = 1'b1; in_data = vecs[k].din;
      cyc();
      in_valid = 1'b0;
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_level", 64'(level), 64'd1);
      chk("mask_data", out_data, vecs[k].dout);
      for (int s = 0; s < 5; s++) begin
        cyc();
        chk("stall_hold", out_data, vecs[k].dout);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end

    // Full / backpressure
    do_clear();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pushed[i] = {$urandom, $urandom};
      in_data = pushed[i];
      cyc();
    end
    in_valid = 1'b0;
    chk("full_level", 64'(level), 64'd8);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", out_data, ref_mask(pushed[i]));
      cyc();
      chk("drain_in_ready", 64'(in_ready), 64'd1);
    end
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Streaming across row and matrix boundaries
    do_clear();
    pops_seen = 0; md_cnt = 0; md_cyc = -1; pop12_cyc = -1; lvl1_cnt = 0; last_mask = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i < 12);
      in_data  = 64'h0100 + 64'(i);
      if (out_valid) begin
        pops_seen++;
        if (out_last) last_mask[pops_seen] = 1'b1;
        if (pops_seen == 12) pop12_cyc = i;
      end
      if (matrix_done) begin md_cnt++; md_cyc = i; end
      if (level == 4'd1) lvl1_cnt++;
      cyc();
    end
    in_valid = 1'b0;
    chk("stream_pops", 64'(pops_seen), 64'd12);
    chk("stream_level1", 64'(lvl1_cnt), 64'd12);
    chk("last_positions", 64'(last_mask), 64'h1110);
    chk("done_count", 64'(md_cnt), 64'd1);
    chk("done_timing", 64'(md_cyc), 64'(pop12_cyc + 1));

    // Flush mid-operation by clear, then by reset
    mid_flush(1'b0);
    mid_flush(1'b1);

    // Randomized traffic against the model, with occasional clears
    do_clear();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 99) == 0);
      in_data   = {$urandom, $urandom};
      cyc();
    end
    idle_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
